// File: rtl/board_state_reg_if.sv
// Move-request and board-status bundle between the position decoders, game control
// and the board-state register.
interface board_state_reg_if;
  logic        new_game;
  logic [15:0] player_en;
  logic [15:0] pc_en;
  logic [8:0]  board_x;
  logic [8:0]  board_o;
  logic        turn;
  logic        illegal_move;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_count;

  modport master (
    output new_game, player_en, pc_en,
    input  board_x, board_o, turn, illegal_move, winner, game_over, move_count
  );

  modport slave (
    input  new_game, player_en, pc_en,
    output board_x, board_o, turn, illegal_move, winner, game_over, move_count
  );
endinterface

// File: rtl/board_state_reg.sv
// Tic-tac-toe board register and turn sequencer: validates one-hot move requests,
// commits marks, and registers the win/draw result.
//
// state  | meaning
// WAIT_P | player to move, only player_en examined
// WAIT_C | computer to move, only pc_en examined
// CHECK  | one-cycle line evaluation for the side that just moved
// DONE   | game finished, everything holds until reset/new_game
module board_state_reg (
  input  logic               clock,
  input  logic               reset,
  board_state_reg_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_P = 2'd0,
    WAIT_C = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [8:0]  board_x;
  logic [8:0]  board_o;
  logic        turn;
  logic        illegal_move;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_count;

  logic [15:0] req;
  logic [8:0]  pos;
  logic        one_pos;
  logic        req_bad;
  logic [8:0]  mover;
  logic        mover_line;

  function automatic logic has_line(input logic [8:0] m);
    return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  always_comb begin
    req        = (state == WAIT_C) ? bus.pc_en : bus.player_en;
    pos        = req[8:0];
    // power-of-two test: exactly one bit set among the nine positions
    one_pos    = (pos != 9'd0) && ((pos & (pos - 9'd1)) == 9'd0);
    req_bad    = (req[15:9] != 7'd0) || !one_pos || ((pos & (board_x | board_o)) != 9'd0);
    mover      = turn ? board_o : board_x;
    mover_line = has_line(mover);
  end

  always_ff @(posedge clock) begin
    if (reset || bus.new_game) begin
      state        <= WAIT_P;
      board_x      <= 9'd0;
      board_o      <= 9'd0;
      turn         <= 1'b0;
      illegal_move <= 1'b0;
      winner       <= 2'b00;
      game_over    <= 1'b0;
      move_count   <= 4'd0;
    end else begin
      illegal_move <= 1'b0;
      case (state)
        WAIT_P, WAIT_C: begin
          if (req != 16'd0) begin
            if (req_bad) begin
              illegal_move <= 1'b1;
            end else begin
              if (state == WAIT_P) board_x <= board_x | pos;
              else                 board_o <= board_o | pos;
              move_count <= move_count + 4'd1;
              state      <= CHECK;
            end
          end
        end
        CHECK: begin
          if (mover_line) begin
            winner    <= turn ? 2'b10 : 2'b01;
            game_over <= 1'b1;
            state     <= DONE;
          end else if (move_count == 4'd9) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= DONE;
          end else begin
            turn  <= ~turn;
            state <= turn ? WAIT_P : WAIT_C;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= WAIT_P;
      endcase
    end
  end

  assign bus.board_x      = board_x;
  assign bus.board_o      = board_o;
  assign bus.turn         = turn;
  assign bus.illegal_move = illegal_move;
  assign bus.winner       = winner;
  assign bus.game_over    = game_over;
  assign bus.move_count   = move_count;

endmodule

// File: tb/tb_board_state_reg.sv
// Directed-vector bench for board_state_reg: reset, legal/illegal moves, turn
// enforcement, win, draw and reset during CHECK.
module tb_board_state_reg;
  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  board_state_reg_if bus ();

  board_state_reg dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {board_x, board_o, turn, illegal_move, winner, game_over, move_count}
  function automatic logic [26:0] snap();
    return {bus.board_x, bus.board_o, bus.turn, bus.illegal_move,
            bus.winner, bus.game_over, bus.move_count};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one request for one edge (commit), drop it, then one edge for CHECK.
  task automatic play(input logic is_pc, input logic [15:0] en);
    if (is_pc) bus.pc_en = en; else bus.player_en = en;
    tick();
    bus.pc_en     = 16'd0;
    bus.player_en = 16'd0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    compared++; if (snap() !== 27'd0) begin mismatched++; $display("FAIL reset_all: got %h expected %h", snap(), 27'd0); end
    tick();
    compared++; if (snap() !== 27'd0) begin mismatched++; $display("FAIL reset_idle: got %h expected %h", snap(), 27'd0); end
  endtask

  task automatic test_basic_moves();
    bus.player_en = 16'h0001;
    tick();
    compared++; if (bus.board_x !== 9'h001) begin mismatched++; $display("FAIL basic_x_commit: got %h expected %h", bus.board_x, 9'h001); end
    compared++; if (bus.move_count !== 4'd1) begin mismatched++; $display("FAIL basic_count1: got %0d expected %0d", bus.move_count, 1); end
    compared++; if (bus.turn !== 1'b0) begin mismatched++; $display("FAIL basic_turn_before_check: got %b expected %b", bus.turn, 1'b0); end
    bus.player_en = 16'd0;
    tick();
    compared++; if (bus.turn !== 1'b1) begin mismatched++; $display("FAIL basic_turn_to_pc: got %b expected %b", bus.turn, 1'b1); end
    bus.pc_en = 16'h0010;
    tick();
    compared++; if (bus.board_o !== 9'h010) begin mismatched++; $display("FAIL basic_o_commit: got %h expected %h", bus.board_o, 9'h010); end
    compared++; if (bus.illegal_move !== 1'b0) begin mismatched++; $display("FAIL basic_no_illegal: got %b expected %b", bus.illegal_move, 1'b0); end
    bus.pc_en = 16'd0;
    tick();
    compared++; if (snap() !== {9'h001, 9'h010, 1'b0, 1'b0, 2'b00, 1'b0, 4'd2}) begin mismatched++; $display("FAIL basic_after_two: got %h expected %h", snap(), {9'h001, 9'h010, 1'b0, 1'b0, 2'b00, 1'b0, 4'd2}); end
  endtask

  task automatic test_illegal();
    logic [15:0] vec [3];
    vec[0] = 16'h0200;
    vec[1] = 16'h0003;
    vec[2] = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      bus.player_en = vec[i];
      tick();
      compared++; if (bus.illegal_move !== 1'b1) begin mismatched++; $display("FAIL illegal_pulse[%0d]: got %b expected %b", i, bus.illegal_move, 1'b1); end
      compared++; if ({bus.board_x, bus.board_o, bus.move_count, bus.turn} !== {9'h001, 9'h010, 4'd2, 1'b0}) begin mismatched++; $display("FAIL illegal_board[%0d]: got %h expected %h", i, {bus.board_x, bus.board_o, bus.move_count, bus.turn}, {9'h001, 9'h010, 4'd2, 1'b0}); end
      bus.player_en = 16'd0;
      tick();
      compared++; if (bus.illegal_move !== 1'b0) begin mismatched++; $display("FAIL illegal_one_cycle[%0d]: got %b expected %b", i, bus.illegal_move, 1'b0); end
    end
  endtask

  task automatic test_wrong_turn();
    bus.pc_en = 16'h0004;
    tick();
    tick();
    compared++; if (snap() !== {9'h001, 9'h010, 1'b0, 1'b0, 2'b00, 1'b0, 4'd2}) begin mismatched++; $display("FAIL wrong_turn_ignored: got %h expected %h", snap(), {9'h001, 9'h010, 1'b0, 1'b0, 2'b00, 1'b0, 4'd2}); end
    // simultaneous requests: only the player's acts
    bus.player_en = 16'h0100;
    tick();
    bus.pc_en     = 16'd0;
    bus.player_en = 16'd0;
    compared++; if ({bus.board_x, bus.board_o} !== {9'h101, 9'h010}) begin mismatched++; $display("FAIL simultaneous: got %h expected %h", {bus.board_x, bus.board_o}, {9'h101, 9'h010}); end
    tick();
  endtask

  task automatic test_win();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    compared++; if (snap() !== 27'd0) begin mismatched++; $display("FAIL new_game_clear1: got %h expected %h", snap(), 27'd0); end
    play(1'b0, 16'h0001);
    play(1'b1, 16'h0008);
    play(1'b0, 16'h0002);
    play(1'b1, 16'h0010);
    bus.player_en = 16'h0004;
    tick();
    bus.player_en = 16'd0;
    compared++; if ({bus.winner, bus.game_over} !== 3'b000) begin mismatched++; $display("FAIL win_not_yet: got %b expected %b", {bus.winner, bus.game_over}, 3'b000); end
    tick();
    compared++; if ({bus.winner, bus.game_over} !== 3'b011) begin mismatched++; $display("FAIL win_player: got %b expected %b", {bus.winner, bus.game_over}, 3'b011); end
    bus.player_en = 16'h0100;
    bus.pc_en     = 16'h0020;
    tick();
    tick();
    bus.player_en = 16'd0;
    bus.pc_en     = 16'd0;
    compared++; if (snap() !== {9'h007, 9'h018, 1'b0, 1'b0, 2'b01, 1'b1, 4'd5}) begin mismatched++; $display("FAIL done_holds: got %h expected %h", snap(), {9'h007, 9'h018, 1'b0, 1'b0, 2'b01, 1'b1, 4'd5}); end
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    compared++; if (snap() !== 27'd0) begin mismatched++; $display("FAIL new_game_clear2: got %h expected %h", snap(), 27'd0); end
  endtask

  task automatic test_draw();
    logic [15:0] seq [9];
    seq = '{16'h0001, 16'h0002, 16'h0004, 16'h0010, 16'h0008,
            16'h0020, 16'h0080, 16'h0040, 16'h0100};
    for (int i = 0; i < 9; i++) play(i[0], seq[i]);
    compared++; if (snap() !== {9'h18D, 9'h072, 1'b0, 1'b0, 2'b11, 1'b1, 4'd9}) begin mismatched++; $display("FAIL draw: got %h expected %h", snap(), {9'h18D, 9'h072, 1'b0, 1'b0, 2'b11, 1'b1, 4'd9}); end
  endtask

  task automatic test_reset_in_check();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    play(1'b0, 16'h0001);
    bus.pc_en = 16'h0002;
    tick();
    bus.pc_en = 16'd0;
    // now in CHECK after the computer commit
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++; if (snap() !== 27'd0) begin mismatched++; $display("FAIL reset_in_check: got %h expected %h", snap(), 27'd0); end
    tick();
    compared++; if (snap() !== 27'd0) begin mismatched++; $display("FAIL reset_in_check_hold: got %h expected %h", snap(), 27'd0); end
    play(1'b0, 16'h0040);
    compared++; if ({bus.board_x, bus.turn, bus.move_count} !== {9'h040, 1'b1, 4'd1}) begin mismatched++; $display("FAIL after_reset_move: got %h expected %h", {bus.board_x, bus.turn, bus.move_count}, {9'h040, 1'b1, 4'd1}); end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b1;
    bus.new_game  = 1'b0;
    bus.player_en = 16'd0;
    bus.pc_en     = 16'd0;
    test_reset();
    test_basic_moves();
    test_illegal();
    test_wrong_turn();
    test_win();
    test_draw();
    test_reset_in_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/board_state_reg.md
# board_state_reg

Board-state register and turn sequencer that sits directly downstream of the 4-to-16 position decoders. Each cycle it consumes the one-hot 16-bit enable words from the player-side and computer-side decoders and commits a legal mark into a 3x3 board (positions 0–8). It enforces turn order and rejects illegal moves. It then registers the win/draw result for the display and game-control logic.

## Interface
Parameters: none. Board size is fixed at 3x3; enable-word width is fixed at 16.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- new_game  in  1  synchronous clear with the same effect as reset, for game-control logic
- player_en  in  16  one-hot enable word from the player position decoder; all-zero means no request
- pc_en  in  16  one-hot enable word from the computer position decoder; all-zero means no request
- board_x  out  9  bit i = 1 means position i holds the player mark (X)
- board_o  out  9  bit i = 1 means position i holds the computer mark (O)
- turn  out  1  0 = player to move, 1 = computer to move
- illegal_move  out  1  one-cycle pulse when a move request on the active turn's input is rejected
- winner  out  2  00 none, 01 player, 10 computer, 11 draw
- game_over  out  1  high when winner != 00; held until reset or new_game
- move_count  out  4  number of committed marks, 0–9

## Operation
- Clock and reset: one clock domain. Reset is synchronous and active-high; new_game behaves identically.
- Reset state: every output is 0. board_x = board_o = 0, turn = 0, illegal_move = 0, winner = 00, game_over = 0, move_count = 0. The FSM goes to WAIT_P.
- FSM states:
  - WAIT_P: player to move. Only player_en is examined; pc_en is ignored silently.
  - WAIT_C: computer to move. Only pc_en is examined; player_en is ignored silently.
  - CHECK: one-cycle win evaluation after a committed move. Both inputs are ignored.
  - DONE: game finished. Both inputs are ignored; all outputs hold.
- Active input: player_en in WAIT_P, pc_en in WAIT_C. Call it `req`.
- Move validation in WAIT_P / WAIT_C:
  - req == 0: no action, stay in the current state.
  - The move is illegal if any of these holds:
    - req[15:9] != 0
    - popcount(req[8:0]) != 1
    - the selected position is already occupied, i.e. (req[8:0] & (board_x | board_o)) != 0
  - Illegal move: illegal_move pulses for one cycle, the board and turn are unchanged, and the FSM stays in the same state. The request is not retried, so the source must change or drop req.
  - Legal move: OR req[8:0] into board_x (WAIT_P) or board_o (WAIT_C), increment move_count, and go to CHECK.
- CHECK evaluates the registered board against the 8 lines: rows {0,1,2},{3,4,5},{6,7,8}; columns {0,3,6},{1,4,7},{2,5,8}; diagonals {0,4,8},{2,4,6}.
  - Line complete for the mover: winner = 01 (X) or 10 (O), game_over = 1, go to DONE.
  - Else if move_count == 9: winner = 11, game_over = 1, go to DONE.
  - Else: toggle turn and go to WAIT_C or WAIT_P accordingly.
- Only the mover's marks are tested in CHECK. The opponent cannot have completed a line since its own last CHECK.
- Simultaneous player_en and pc_en: only the active-turn input can act.
- Reset or new_game in any state, including CHECK mid-evaluation, takes priority over every other action.

## Timing
- Legal move at rising edge N:
  - board_x / board_o and move_count update at edge N.
  - The FSM is in CHECK during cycle N+1.
  - winner, game_over and turn update at edge N+1.
  - Minimum move-to-move spacing is 2 cycles.
- Illegal move at edge N: illegal_move is high during cycle N+1 only.
- A request held high for several cycles in WAIT_P/WAIT_C is evaluated on every cycle in those states. A legal move therefore commits once; the position is then occupied, so a held request is flagged illegal once the turn comes back to that input.
- All outputs are registered with no combinational path from input to output.

## Test plan
- Reset → board_x = board_o = 0, turn = 0, winner = 00, game_over = 0, move_count = 0.
- player_en = 0x0001, then (after CHECK) pc_en = 0x0010 → board_x = 0x001, board_o = 0x010, move_count = 2, turn back to 0, illegal_move never asserted.
- Illegal moves in WAIT_P:
  - player_en = 0x0200 (position 9): illegal_move pulses 1 cycle, board unchanged.
  - player_en = 0x0003 (two bits set): illegal_move pulses 1 cycle, board unchanged.
  - player_en = 0x0010 after pc holds position 4: illegal_move pulses 1 cycle, board unchanged.
- Wrong-turn stimulus: pc_en = 0x0004 in WAIT_P → ignored, illegal_move = 0, board unchanged.
- Win: player takes positions 0, 1, 2 while pc takes 3 and 4 → winner = 01 and game_over = 1 one cycle after the 0x0004 commit. Subsequent inputs change nothing; new_game clears all outputs to 0.
- Draw: play the sequence X0, O1, X2, O4, X3, O5, X7, O6, X8 → move_count = 9, winner = 11, game_over = 1. Assert reset during a CHECK cycle → all outputs are 0 on the next edge.
